// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and constants used by the pipeline stages.
package cpu_types_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t PC_STEP = word_t'(4);

   typedef enum logic [1:0] {
      FETCH,
      BUFFERED,
      HALTED
   } fetch_state_t;

   typedef struct packed {
      word_t instr;
      word_t npc;
      logic  valid;
   } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC/icache inputs, pipeline control, and IF/ID outputs.
interface fetch_stage_if;
   import cpu_types_pkg::*;

   word_t pc_i;
   word_t imemload;
   logic  ihit;
   logic  stall;
   logic  flush;
   logic  halt;
   logic  imemREN;
   word_t imemaddr;
   logic  pc_en;
   word_t instr_o;
   word_t npc_o;
   logic  valid_o;

   modport master (
      output pc_i, imemload, ihit, stall, flush, halt,
      input  imemREN, imemaddr, pc_en, instr_o, npc_o, valid_o
   );

   modport slave (
      input  pc_i, imemload, ihit, stall, flush, halt,
      output imemREN, imemaddr, pc_en, instr_o, npc_o, valid_o
   );
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline latch: load wins over clear; clear only drops the valid bit.
module ifid_reg
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  nRST,
   input  logic  i_load,
   input  logic  i_clear,
   input  ifid_t i_d,
   output ifid_t o_q
);

   ifid_t r_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end else if (i_clear) begin
         r_q.valid <= 1'b0;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a one-entry skid buffer so an ihit during a
// decode stall is held until decode can take it.
module fetch_stage
   import cpu_types_pkg::*;
(
   input logic          CLK,
   input logic          nRST,
   fetch_stage_if.slave bus
);

   fetch_state_t r_state;
   word_t        r_skid_instr;
   word_t        r_skid_npc;
   word_t        w_npc;
   logic         w_pc_en;
   logic         w_load;
   logic         w_clear;
   ifid_t        w_ifid_d;
   ifid_t        w_ifid_q;

   assign w_npc = bus.pc_i + PC_STEP;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state      <= FETCH;
         r_skid_instr <= '0;
         r_skid_npc   <= '0;
      end else begin
         unique case (r_state)
            FETCH: begin
               if (bus.halt) begin
                  r_state <= HALTED;
               end else if (!bus.flush && bus.ihit && bus.stall) begin
                  r_skid_instr <= bus.imemload;
                  r_skid_npc   <= w_npc;
                  r_state      <= BUFFERED;
               end
            end
            BUFFERED: begin
               if (bus.halt) begin
                  r_state <= HALTED;
               end else if (bus.flush || !bus.stall) begin
                  r_state <= FETCH;
               end
            end
            HALTED:  r_state <= HALTED;
            default: r_state <= FETCH;
         endcase
      end
   end

   always_comb begin
      w_pc_en  = 1'b0;
      w_load   = 1'b0;
      w_clear  = 1'b0;
      w_ifid_d = '{instr: bus.imemload, npc: w_npc, valid: 1'b1};
      unique case (r_state)
         FETCH: begin
            if (bus.halt || bus.flush) begin
               w_clear = 1'b1;
            end else if (bus.ihit) begin
               w_pc_en = 1'b1;
               w_load  = !bus.stall;
            end else if (!bus.stall) begin
               w_clear = 1'b1;
            end
         end
         BUFFERED: begin
            w_ifid_d = '{instr: r_skid_instr, npc: r_skid_npc, valid: 1'b1};
            if (bus.halt) begin
               w_clear = 1'b0;
            end else if (bus.flush) begin
               w_clear = 1'b1;
            end else if (!bus.stall) begin
               w_load = 1'b1;
            end
         end
         HALTED:  w_clear = 1'b1;
         default: w_clear = 1'b1;
      endcase
   end

   ifid_reg u_ifid_reg (
      .CLK     (CLK),
      .nRST    (nRST),
      .i_load  (w_load),
      .i_clear (w_clear),
      .i_d     (w_ifid_d),
      .o_q     (w_ifid_q)
   );

   assign bus.imemREN  = (r_state == FETCH);
   assign bus.imemaddr = bus.pc_i;
   assign bus.pc_en    = w_pc_en;
   assign bus.instr_o  = w_ifid_q.instr;
   assign bus.npc_o    = w_ifid_q.npc;
   assign bus.valid_o  = w_ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a queue-based model.
module tb_fetch_stage;
   import cpu_types_pkg::*;

   logic CLK;
   logic nRST;
   int   checks;
   int   errors;

   fetch_stage_if bus ();

   fetch_stage u_dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Model: halted flag, skid as a queue of {instr, npc}, and the IF/ID contents.
   bit          m_halted;
   logic [63:0] m_skid[$];
   word_t       m_instr;
   word_t       m_npc;
   logic        m_valid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_halted = 1'b0;
      m_skid.delete();
      m_instr = '0;
      m_npc   = '0;
      m_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      bus.ihit = 1'b0;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bus.halt = 1'b0;
      #2;
      nRST = 1'b0;
      model_reset();
      #1;
      chk("rst_valid", 32'(bus.valid_o), 32'(m_valid));
      chk("rst_instr", bus.instr_o, m_instr);
      chk("rst_npc", bus.npc_o, m_npc);
      chk("rst_ren", 32'(bus.imemREN), 32'd1);
      chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic step(input word_t pc, input word_t ld, input bit ih, input bit st,
                       input bit fl, input bit hl);
      bit    fetching;
      logic  e_pc_en;
      logic [63:0] e;
      @(negedge CLK);
      bus.pc_i = pc;
      bus.imemload = ld;
      bus.ihit = ih;
      bus.stall = st;
      bus.flush = fl;
      bus.halt = hl;
      #1;
      fetching = !m_halted && (m_skid.size() == 0);
      e_pc_en  = fetching && !hl && !fl && ih;
      chk("imemREN", 32'(bus.imemREN), 32'(fetching));
      chk("imemaddr", bus.imemaddr, pc);
      chk("pc_en", 32'(bus.pc_en), 32'(e_pc_en));
      if (m_halted) begin
         m_valid = 1'b0;
      end else if (fetching) begin
         if (hl) begin
            m_halted = 1'b1;
            m_valid = 1'b0;
         end else if (fl) begin
            m_valid = 1'b0;
         end else if (ih && st) begin
            m_skid.push_back({ld, pc + 32'd4});
         end else if (ih) begin
            m_instr = ld;
            m_npc = pc + 32'd4;
            m_valid = 1'b1;
         end else if (!st) begin
            m_valid = 1'b0;
         end
      end else begin
         if (hl) begin
            m_halted = 1'b1;
         end else if (fl) begin
            m_skid.delete();
            m_valid = 1'b0;
         end else if (!st) begin
            e = m_skid.pop_front();
            m_instr = e[63:32];
            m_npc = e[31:0];
            m_valid = 1'b1;
         end
      end
      @(posedge CLK);
      #1;
      chk("valid_o", 32'(bus.valid_o), 32'(m_valid));
      chk("instr_o", bus.instr_o, m_instr);
      chk("npc_o", bus.npc_o, m_npc);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      nRST = 1'b1;
      bus.pc_i = '0;
      bus.imemload = '0;
      bus.ihit = 1'b0;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bus.halt = 1'b0;
      model_reset();
      do_reset();

      // Streaming fetch
      step(32'h0, 32'hAAAA_0001, 1, 0, 0, 0);
      chk("stream_a", bus.instr_o, 32'hAAAA_0001);
      step(32'h4, 32'hBBBB_0002, 1, 0, 0, 0);
      step(32'h8, 32'hCCCC_0003, 1, 0, 0, 0);
      chk("stream_c_npc", bus.npc_o, 32'd12);

      // Skid then release
      step(32'h10, 32'h0000_DEAD, 1, 1, 0, 0);
      step(32'h14, 32'h1111_1111, 1, 1, 0, 0);
      step(32'h14, 32'h1111_1111, 0, 0, 0, 0);
      chk("skid_instr", bus.instr_o, 32'h0000_DEAD);
      chk("skid_npc", bus.npc_o, 32'h14);

      // Flush over buffered entry
      step(32'h20, 32'h2222_2222, 1, 1, 0, 0);
      step(32'h24, 32'h3333_3333, 0, 1, 1, 0);
      chk("flush_valid", 32'(bus.valid_o), 32'd0);

      // Wrap-around npc
      step(32'hFFFF_FFFC, 32'h4444_4444, 1, 0, 0, 0);
      chk("wrap_npc", bus.npc_o, 32'h0);

      // Halt is absorbing
      step(32'h30, 32'h5555_5555, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(32'h34, 32'h6666_6666, 1, 0, 0, 0);
      do_reset();

      // Randomized traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         word_t pc;
         pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom();
         if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
         step(pc, $urandom(), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
         if ($urandom_range(0, 59) == 0) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
